// File: rtl/mega_regs.sv
// Register file: 32 x 8-bit GPRs, SREG and X/Y/Z pointer pairs with post-inc/pre-dec.
// Optional same-cycle write-through forwarding when MEGA_REGS_BYPASS_EN is defined.
module mega_regs #(
    parameter PLATFORM = "XILINX"
) (
    input  logic        rst,
    input  logic        clk,
    input  logic [4:0]  rda,
    input  logic        rd_16,
    output logic [15:0] rd,
    input  logic [4:0]  rra,
    input  logic        rr_16,
    output logic [15:0] rr,
    input  logic        wr_en,
    input  logic        wr_16,
    input  logic [4:0]  wra,
    input  logic [15:0] wr_data,
    input  logic        sreg_wr,
    input  logic [7:0]  sreg_in,
    output logic [7:0]  sreg,
    input  logic [1:0]  ptr_sel,
    input  logic        ptr_inc,
    input  logic        ptr_dec,
    output logic [15:0] ptr_addr,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] z
);

    // Technology selection has no functional effect on this block.
    if (PLATFORM != "") begin : g_platform
    end

    logic [7:0]  regs_reg [32];
    logic [7:0]  view [32];
    logic [7:0]  sreg_reg;
    logic [31:0] wr_hit;
    logic [4:0]  ptr_base_lo;
    logic [4:0]  ptr_base_hi;
    logic [15:0] ptr_val;
    logic [15:0] ptr_next;
    logic        ptr_hit;
    logic        ptr_upd;

    always_comb begin
        wr_hit = '0;
        if (wr_en) begin
            if (wr_16) begin
                wr_hit[{wra[4:1], 1'b0}] = 1'b1;
                wr_hit[{wra[4:1], 1'b1}] = 1'b1;
            end else begin
                wr_hit[wra] = 1'b1;
            end
        end
    end

    // X/Y/Z live at r26/r28/r30, i.e. base = 24 + 2*ptr_sel.
    assign ptr_base_lo = {2'b11, ptr_sel, 1'b0};
    assign ptr_base_hi = {2'b11, ptr_sel, 1'b1};
    assign ptr_val     = {regs_reg[ptr_base_hi], regs_reg[ptr_base_lo]};
    assign ptr_next    = ptr_inc ? ptr_val + 16'd1 : ptr_val - 16'd1;
    // A write-port hit on either pointer byte cancels the whole pointer update.
    assign ptr_hit     = wr_hit[ptr_base_lo] | wr_hit[ptr_base_hi];
    assign ptr_upd     = (ptr_sel != 2'b00) && (ptr_inc ^ ptr_dec) && !ptr_hit;

    always_comb begin
        ptr_addr = 16'h0000;
        if (ptr_sel != 2'b00) begin
            ptr_addr = (ptr_dec && !ptr_inc) ? ptr_val - 16'd1 : ptr_val;
        end
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
        localparam logic [4:0] IDX = 5'(gi);
        logic [7:0] wdata_byte;
        logic [7:0] ptr_byte;
        logic       ptr_byte_en;

        assign wdata_byte  = (wr_16 && IDX[0]) ? wr_data[15:8] : wr_data[7:0];
        assign ptr_byte    = IDX[0] ? ptr_next[15:8] : ptr_next[7:0];
        assign ptr_byte_en = ptr_upd && (IDX[4:1] == ptr_base_lo[4:1]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regs_reg[gi] <= 8'h00;
            end else if (wr_hit[gi]) begin
                regs_reg[gi] <= wdata_byte;
            end else if (ptr_byte_en) begin
                regs_reg[gi] <= ptr_byte;
            end
        end

`ifdef MEGA_REGS_BYPASS_EN
        assign view[gi] = (wr_hit[gi] && !rst) ? wdata_byte : regs_reg[gi];
`else
        assign view[gi] = regs_reg[gi];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_reg <= 8'h00;
        end else if (sreg_wr) begin
            sreg_reg <= sreg_in;
        end
    end

`ifdef MEGA_REGS_BYPASS_EN
    assign sreg = (sreg_wr && !rst) ? sreg_in : sreg_reg;
`else
    assign sreg = sreg_reg;
`endif

    assign rd = rd_16 ? {view[{rda[4:1], 1'b1}], view[{rda[4:1], 1'b0}]} : {8'h00, view[rda]};
    assign rr = rr_16 ? {view[{rra[4:1], 1'b1}], view[{rra[4:1], 1'b0}]} : {8'h00, view[rra]};
    assign x  = {view[27], view[26]};
    assign y  = {view[29], view[28]};
    assign z  = {view[31], view[30]};

endmodule

// File: tb/tb_mega_regs.sv
// Directed self-checking bench for mega_regs: reset, pair access, pointers, collision, bypass, SREG.
module tb_mega_regs;

    logic        rst;
    logic        clk;
    logic [4:0]  rda;
    logic        rd_16;
    logic [15:0] rd;
    logic [4:0]  rra;
    logic        rr_16;
    logic [15:0] rr;
    logic        wr_en;
    logic        wr_16;
    logic [4:0]  wra;
    logic [15:0] wr_data;
    logic        sreg_wr;
    logic [7:0]  sreg_in;
    logic [7:0]  sreg;
    logic [1:0]  ptr_sel;
    logic        ptr_inc;
    logic        ptr_dec;
    logic [15:0] ptr_addr;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;

    int total = 0;
    int bad = 0;

    mega_regs #(.PLATFORM("XILINX")) dut (
        .rst(rst), .clk(clk),
        .rda(rda), .rd_16(rd_16), .rd(rd),
        .rra(rra), .rr_16(rr_16), .rr(rr),
        .wr_en(wr_en), .wr_16(wr_16), .wra(wra), .wr_data(wr_data),
        .sreg_wr(sreg_wr), .sreg_in(sreg_in), .sreg(sreg),
        .ptr_sel(ptr_sel), .ptr_inc(ptr_inc), .ptr_dec(ptr_dec), .ptr_addr(ptr_addr),
        .x(x), .y(y), .z(z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_16 = 0; wra = 0; wr_data = 0;
        sreg_wr = 0; sreg_in = 0;
        ptr_sel = 0; ptr_inc = 0; ptr_dec = 0;
        rd_16 = 0; rr_16 = 0; rda = 0; rra = 0;
    endtask

    task automatic load_pair(input logic [4:0] a, input logic [15:0] d);
        wr_en = 1; wr_16 = 1; wra = a; wr_data = d;
        tick();
        wr_en = 0; wr_16 = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick();
        #1;
        total++;
        if ({rd, rr, sreg, x, y, z, ptr_addr} !== 104'h0) begin
            bad++;
            $display("FAIL reset_state: rd=%h rr=%h sreg=%h x=%h y=%h z=%h ptr=%h required all zero",
                     rd, rr, sreg, x, y, z, ptr_addr);
        end
        @(negedge clk); rst = 0;
        wr_en = 1; wra = 5; wr_data = 16'h00A5; sreg_wr = 1; sreg_in = 8'hFF;
        tick();
        idle(); rda = 5;
        #1;
        total++;
        if (rd !== 16'h00A5 || sreg !== 8'hFF) begin
            bad++;
            $display("FAIL reset_preload: rd=%h sreg=%h required 00a5/ff", rd, sreg);
        end
        #2 rst = 1;
        #1;
        total++;
        if (rd !== 16'h0000 || sreg !== 8'h00) begin
            bad++;
            $display("FAIL reset_async: rd=%h sreg=%h required 0000/00", rd, sreg);
        end
        wr_en = 1; wra = 5; wr_data = 16'h0011; sreg_wr = 1; sreg_in = 8'h22;
        tick();
        total++;
        if (rd !== 16'h0000 || sreg !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold: rd=%h sreg=%h required 0000/00", rd, sreg);
        end
        idle(); rda = 5;
        @(negedge clk); rst = 0;
        tick();
        $display("reset: rd=%h sreg=%h", rd, sreg);
    endtask

    task automatic test_pair_write();
        idle();
        load_pair(5'd25, 16'h1234);
        rda = 24; rd_16 = 1; rra = 25; rr_16 = 0;
        #1;
        total++;
        if (rd !== 16'h1234) begin
            bad++;
            $display("FAIL pair_read_a: rd=%h required 1234", rd);
        end
        total++;
        if (rr !== 16'h0012) begin
            bad++;
            $display("FAIL byte_read_r25: rr=%h required 0012", rr);
        end
        rra = 24;
        #1;
        total++;
        if (rr !== 16'h0034) begin
            bad++;
            $display("FAIL byte_read_r24: rr=%h required 0034", rr);
        end
        rra = 25; rr_16 = 1;
        #1;
        total++;
        if (rr !== 16'h1234) begin
            bad++;
            $display("FAIL pair_read_b_odd: rr=%h required 1234", rr);
        end
        $display("pair_write: rd=%h rr=%h", rd, rr);
    endtask

    task automatic test_ptr_wrap();
        idle();
        load_pair(5'd30, 16'hFFFF);
        ptr_sel = 2'b11; ptr_inc = 1;
        #1;
        total++;
        if (ptr_addr !== 16'hFFFF) begin
            bad++;
            $display("FAIL ptr_inc_addr: ptr_addr=%h required ffff", ptr_addr);
        end
        tick();
        ptr_inc = 0;
        #1;
        total++;
        if (z !== 16'h0000 || ptr_addr !== 16'h0000) begin
            bad++;
            $display("FAIL ptr_inc_wrap: z=%h ptr_addr=%h required 0000/0000", z, ptr_addr);
        end
        ptr_dec = 1;
        #1;
        total++;
        if (ptr_addr !== 16'hFFFF) begin
            bad++;
            $display("FAIL ptr_dec_addr: ptr_addr=%h required ffff", ptr_addr);
        end
        tick();
        ptr_inc = 1;
        #1;
        total++;
        if (z !== 16'hFFFF || ptr_addr !== 16'hFFFF) begin
            bad++;
            $display("FAIL ptr_dec_wrap_both: z=%h ptr_addr=%h required ffff/ffff", z, ptr_addr);
        end
        tick();
        total++;
        if (z !== 16'hFFFF) begin
            bad++;
            $display("FAIL ptr_both_noop: z=%h required ffff", z);
        end
        ptr_sel = 2'b00; ptr_dec = 0;
        #1;
        total++;
        if (ptr_addr !== 16'h0000) begin
            bad++;
            $display("FAIL ptr_none_addr: ptr_addr=%h required 0000", ptr_addr);
        end
        tick();
        total++;
        if (z !== 16'hFFFF || x !== 16'h0000) begin
            bad++;
            $display("FAIL ptr_none_ignored: z=%h x=%h required ffff/0000", z, x);
        end
        $display("ptr_wrap: z=%h ptr_addr=%h", z, ptr_addr);
    endtask

    task automatic test_collision();
        idle();
        load_pair(5'd26, 16'h0100);
        ptr_sel = 2'b01; ptr_inc = 1;
        wr_en = 1; wra = 27; wr_data = 16'h0055;
        tick();
        idle();
        #1;
        total++;
        if (x !== 16'h5500) begin
            bad++;
            $display("FAIL collision_x: x=%h required 5500", x);
        end
        load_pair(5'd28, 16'h0010);
        ptr_sel = 2'b10; ptr_dec = 1;
        wr_en = 1; wra = 2; wr_data = 16'h0099;
        #1;
        total++;
        if (ptr_addr !== 16'h000F) begin
            bad++;
            $display("FAIL y_predec_addr: ptr_addr=%h required 000f", ptr_addr);
        end
        tick();
        idle();
        #1;
        total++;
        if (y !== 16'h000F) begin
            bad++;
            $display("FAIL y_dec_no_collision: y=%h required 000f", y);
        end
        $display("collision: x=%h y=%h", x, y);
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
        idle();
`ifdef MEGA_REGS_BYPASS_EN
        exp_same = 16'h007E;
`else
        exp_same = 16'h0000;
`endif
        wr_en = 1; wra = 3; wr_data = 16'h007E; rda = 3;
        #1;
        total++;
        if (rd !== exp_same) begin
            bad++;
            $display("FAIL bypass_same_cycle: rd=%h required %h", rd, exp_same);
        end
        tick();
        wr_en = 0;
        #1;
        total++;
        if (rd !== 16'h007E) begin
            bad++;
            $display("FAIL bypass_next_cycle: rd=%h required 007e", rd);
        end
        $display("bypass: rd=%h", rd);
    endtask

    task automatic test_sreg();
        logic [7:0] exp_same;
        idle();
        sreg_wr = 1; sreg_in = 8'h03;
        tick();
        sreg_wr = 0; sreg_in = 8'hFF;
        #1;
        total++;
        if (sreg !== 8'h03) begin
            bad++;
            $display("FAIL sreg_load: sreg=%h required 03", sreg);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sreg !== 8'h03) begin
                bad++;
                $display("FAIL sreg_hold%0d: sreg=%h required 03", i, sreg);
            end
        end
`ifdef MEGA_REGS_BYPASS_EN
        exp_same = 8'h5A;
`else
        exp_same = 8'h03;
`endif
        sreg_wr = 1; sreg_in = 8'h5A;
        #1;
        total++;
        if (sreg !== exp_same) begin
            bad++;
            $display("FAIL sreg_same_cycle: sreg=%h required %h", sreg, exp_same);
        end
        tick();
        sreg_wr = 0;
        $display("sreg: sreg=%h", sreg);
    endtask

    initial begin
        test_reset();
        test_pair_write();
        test_ptr_wrap();
        test_collision();
        test_bypass();
        test_sreg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mega_regs.md
MEGA_REGS -- requirements
Module: mega_regs

Interface
REQ-001 SHALL provide parameter PLATFORM, default "XILINX": target technology selector, no functional effect.
REQ-002 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rda  input  5  read port A address; drives ALU rd operand.
REQ-005 SHALL provide port rd_16  input  1  port A pair read.
REQ-006 SHALL provide port rd  output  16  port A data.
REQ-007 SHALL provide port rra  input  5  read port B address; drives ALU rr operand.
REQ-008 SHALL provide port rr_16  input  1  port B pair read.
REQ-009 SHALL provide port rr  output  16  port B data.
REQ-010 SHALL provide port wr_en  input  1  write strobe for ALU result R.
REQ-011 SHALL provide port wr_16  input  1  pair write (MOVW/ADIW/SBIW/MUL family).
REQ-012 SHALL provide port wra  input  5  write address.
REQ-013 SHALL provide port wr_data  input  16  write data (ALU R).
REQ-014 SHALL provide port sreg_wr  input  1  SREG write strobe.
REQ-015 SHALL provide port sreg_in  input  8  new SREG value (ALU sreg_out).
REQ-016 SHALL provide port sreg  output  8  current SREG; feeds ALU sreg_in.
REQ-017 SHALL provide port ptr_sel  input  2  pointer select: 00 none, 01 X(r27:r26), 10 Y(r29:r28), 11 Z(r31:r30).
REQ-018 SHALL provide port ptr_inc / ptr_dec  input  1 each  post-increment / pre-decrement request.
REQ-019 SHALL provide port ptr_addr  output  16  effective data address for the selected pointer.
REQ-020 SHALL provide port x / y / z  output  16 each  current X, Y, Z pair values.

Function
REQ-021 SHALL hold 32 x 8-bit registers r0..r31 and one 8-bit SREG register.
REQ-022 Byte read SHALL return {8'h00, r[addr]}; pair read SHALL return {r[addr|1], r[addr&~1]} (addr bit 0 ignored).
REQ-023 Reads SHALL be combinational from stored state; write latency SHALL be 1 cycle (value visible after the wr_en edge).
REQ-024 wr_en with wr_16=0 SHALL write wr_data[7:0] to r[wra]; with wr_16=1 SHALL write wr_data[7:0] to r[wra&~1] and wr_data[15:8] to r[wra|1].
REQ-025 sreg_wr SHALL load sreg_in into SREG at the edge; otherwise SREG holds.
REQ-026 ptr_addr SHALL equal pointer value for ptr_inc or no op, and pointer-1 (mod 2^16) for ptr_dec; equals 16'h0000 when ptr_sel=00.
REQ-027 At the edge, ptr_inc SHALL store pointer+1, ptr_dec SHALL store pointer-1, both mod 2^16 (FFFF+1 -> 0000, 0000-1 -> FFFF).
REQ-028 ptr_inc and ptr_dec both high SHALL perform no update; ptr_addr = current pointer.
REQ-029 ptr_inc/ptr_dec with ptr_sel=00 SHALL be ignored.
REQ-030 If a write-port write touches either byte of the selected pointer pair in the same cycle, the write port SHALL win and the pointer update SHALL be discarded entirely.
REQ-031 Writes to r26..r31 SHALL be reflected on x/y/z one cycle later, identically to any other read.

Reset
REQ-032 rst high SHALL asynchronously clear r0..r31, SREG and all outputs derived from them to zero, independent of clk.
REQ-033 While rst is high, writes, SREG loads and pointer updates SHALL be ignored; an operation in progress at reset assertion SHALL have no effect.
REQ-034 First update after rst deassertion SHALL occur on the first following rising clk edge.

Configuration
REQ-035 Macro MEGA_REGS_BYPASS_EN SHALL control write-through forwarding.
REQ-036 With MEGA_REGS_BYPASS_EN defined, rd/rr/x/y/z/sreg SHALL combinationally reflect same-cycle wr_en/wr_data and sreg_wr/sreg_in for overlapping bytes (per-byte, honouring wr_16).
REQ-037 Without MEGA_REGS_BYPASS_EN, all outputs SHALL reflect only stored state (REQ-023).

Verification
REQ-038 Reset: preload r5=8'hA5, SREG=8'hFF, assert rst mid-cycle -> rd(rda=5)=0 and sreg=0 immediately, before any clk edge.
REQ-039 Pair write: wr_en, wr_16, wra=25 (odd), wr_data=16'h1234 -> r24=8'h34, r25=8'h12; rd_16 read rda=24 returns 16'h1234.
REQ-040 Pointer wrap: Z=16'hFFFF, ptr_sel=11, ptr_inc -> ptr_addr=FFFF, z=0000 next cycle; then ptr_dec -> ptr_addr=FFFF, z=FFFF.
REQ-041 Collision: X=16'h0100, ptr_sel=01, ptr_inc with wr_en byte write wra=27 data 8'h55 same cycle -> x=16'h5500.
REQ-042 Bypass: wr_en wra=3 data 8'h7E, rda=3 same cycle -> rd=16'h007E with MEGA_REGS_BYPASS_EN, old value without; both show 007E next cycle.
REQ-043 SREG: sreg_wr with sreg_in=8'h03 -> sreg=8'h03 next cycle; sreg_wr low for 3 cycles with sreg_in=8'hFF -> sreg stays 8'h03.
